// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit.
//   - EX-stage operand forwarding selects (MEM over WB, x0 never forwards)
//   - load-use stall detection and taken-branch flushes
//   - IDLE/BUSY FSM that holds the front of the pipeline while a
//     multi-cycle MUL/DIV occupies EX for MDLAT cycles
// Optional: define HAZ_STATS_EN to add 32-bit StallCnt / FlushCnt counters.
//
// state | meaning
// IDLE  | no multi-cycle op in progress; a MulDivE here starts a sequence
// BUSY  | multi-cycle op held in EX; cnt counts remaining stall cycles
module hazard_ctrl #(
    parameter int MDLAT = 4,
    parameter int CNTW  = $clog2(MDLAT) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MulDivE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusy,
    output logic       MulDivDoneE
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // With MDLAT==1 the op completes in its first EX cycle, so the FSM never leaves IDLE.
    localparam bit             MD_EN    = (MDLAT >= 2);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'((MDLAT >= 2) ? (MDLAT - 2) : 0);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            lw_stall;
    logic            md_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    // Operand forwarding selects for both EX sources.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end

    // Hazard detection and the stall/flush equations built from it.
    always_comb begin
        lw_stall    = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
        md_stall    = (state == IDLE) ? (MD_EN && MulDivE) : (cnt != '0);
        MulDivDoneE = (state == BUSY) && (cnt == '0);
        MdBusy      = (state == BUSY);
        StallF      = lw_stall | md_stall;
        StallD      = lw_stall | md_stall;
        StallE      = md_stall;
        FlushD      = PCSrcE;
        FlushE      = (lw_stall | PCSrcE) & ~md_stall;
        FlushM      = md_stall;
    end

    // Multi-cycle occupancy FSM; cnt holds the stall cycles still to go after this one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MD_EN && MulDivE) begin
                        cnt   <= CNT_INIT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - CNTW'(1);
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD) StallCnt <= StallCnt + 32'd1;
            if (FlushE) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MDLAT=4). Inputs change on the falling
// edge; outputs are sampled 1 ns later, well clear of the rising edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MulDivE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MulDivDoneE;
`ifdef HAZ_STATS_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int errors = 0;
    int checks = 0;
    bit done_seen = 0;
    bit watch_done = 0;

    hazard_ctrl #(.MDLAT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MdBusy(MdBusy), .MulDivDoneE(MulDivDoneE)
`ifdef HAZ_STATS_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: illegal input combinations and stray done pulses.
    always @(negedge clk) begin
        #3;
        if (PCSrcE && MulDivE) begin
            $display("FAIL protocol: PCSrcE=%0b with MulDivE=%0b", PCSrcE, MulDivE);
            errors++;
        end
        if ((ResultSrcE == 2'b01) && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D)) && StallE) begin
            $display("FAIL protocol: load-use hazard while mdStall active");
            errors++;
        end
        if (watch_done && MulDivDoneE) done_seen = 1'b1;
    end

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0; MulDivE = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (MdBusy !== 1'b0 || MulDivDoneE !== 1'b0) begin
            $display("FAIL reset_fsm: MdBusy=%b MulDivDoneE=%b required 0 0", MdBusy, MulDivDoneE);
            errors++;
        end
        checks++;
        if ({StallF, StallD, StallE, FlushD, FlushE, FlushM} !== 6'b0) begin
            $display("FAIL reset_ctl: stall/flush=%b required 000000",
                     {StallF, StallD, StallE, FlushD, FlushE, FlushM});
            errors++;
        end
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0) begin
            $display("FAIL reset_fwd: fwd=%b required 0000", {ForwardAE, ForwardBE});
            errors++;
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
        #1;
        checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            $display("FAIL fwd_mem_prio: A=%b B=%b required 10 10", ForwardAE, ForwardBE);
            errors++;
        end
        RegWriteM = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            $display("FAIL fwd_wb: A=%b required 01", ForwardAE);
            errors++;
        end
        RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            $display("FAIL fwd_x0: A=%b required 00", ForwardAE);
            errors++;
        end
        RdM = 3; Rs1E = 3; RdW = 9; Rs2E = 9;
        #1;
        checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b01) begin
            $display("FAIL fwd_split: A=%b B=%b required 10 01", ForwardAE, ForwardBE);
            errors++;
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
            $display("FAIL lw_rs2: SF/SD/FE/SE=%b required 1110", {StallF, StallD, FlushE, StallE});
            errors++;
        end
        RdE = 0; Rs2D = 0;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
            $display("FAIL lw_x0: SF/SD/FE/SE=%b required 0000", {StallF, StallD, FlushE, StallE});
            errors++;
        end
        RdE = 12; Rs1D = 12;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
            $display("FAIL lw_rs1: SF/SD/FE/SE=%b required 1110", {StallF, StallD, FlushE, StallE});
            errors++;
        end
        ResultSrcE = 2'b00;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
            $display("FAIL lw_not_load: SF/SD/FE/SE=%b required 0000", {StallF, StallD, FlushE, StallE});
            errors++;
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        @(negedge clk);
        PCSrcE = 1;
        #1;
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            $display("FAIL branch: FD/FE/SF/SD=%b required 1100", {FlushD, FlushE, StallF, StallD});
            errors++;
        end
        ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        #1;
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin
            $display("FAIL branch_lw: FD/FE/SF/SD=%b required 1111", {FlushD, FlushE, StallF, StallD});
            errors++;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        @(negedge clk);
        MulDivE = 1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            exp = ((k % 4) < 3) ? 6'b111100 : 6'b000001;
            checks++;
            if ({StallF, StallD, StallE, FlushM, FlushE, MulDivDoneE} !== exp) begin
                $display("FAIL md_cycle%0d: SF/SD/SE/FM/FE/done=%b required %b", k,
                         {StallF, StallD, StallE, FlushM, FlushE, MulDivDoneE}, exp);
                errors++;
            end
            checks++;
            if (MdBusy !== ((k % 4) != 0)) begin
                $display("FAIL md_busy%0d: MdBusy=%b required %b", k, MdBusy, ((k % 4) != 0));
                errors++;
            end
        end
        @(negedge clk);
        MulDivE = 0;
        #1;
        checks++;
        if ({MdBusy, StallE, MulDivDoneE} !== 3'b000) begin
            $display("FAIL md_idle: busy/SE/done=%b required 000", {MdBusy, StallE, MulDivDoneE});
            errors++;
        end
    endtask

    task automatic test_reset_mid_op();
        done_seen = 0;
        watch_done = 1;
        @(negedge clk);
        MulDivE = 1;
        @(negedge clk);
        #1;
        checks++;
        if (MdBusy !== 1'b1) begin
            $display("FAIL abort_busy: MdBusy=%b required 1", MdBusy);
            errors++;
        end
        reset = 1;
        @(negedge clk);
        reset = 0; MulDivE = 0;
        #1;
        checks++;
        if ({MdBusy, StallF, StallD, StallE, MulDivDoneE} !== 5'b0) begin
            $display("FAIL abort_state: busy/SF/SD/SE/done=%b required 00000",
                     {MdBusy, StallF, StallD, StallE, MulDivDoneE});
            errors++;
        end
        repeat (5) @(negedge clk);
        #4;
        watch_done = 0;
        checks++;
        if (done_seen !== 1'b0) begin
            $display("FAIL abort_no_done: done seen=%b required 0", done_seen);
            errors++;
        end
    endtask

`ifdef HAZ_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
            $display("FAIL stats_reset: StallCnt=%0d FlushCnt=%0d required 0 0", StallCnt, FlushCnt);
            errors++;
        end
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        repeat (2) @(negedge clk);
        clear_inputs();
        PCSrcE = 1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (StallCnt !== 32'd2 || FlushCnt !== 32'd3) begin
            $display("FAIL stats_count: StallCnt=%0d FlushCnt=%0d required 2 3", StallCnt, FlushCnt);
            errors++;
        end
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
            $display("FAIL stats_clear: StallCnt=%0d FlushCnt=%0d required 0 0", StallCnt, FlushCnt);
            errors++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_reset_mid_op();
`ifdef HAZ_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
